mem_fetch_ctrl: RTL
===================

# mem_fetch_ctrl

Memory fetch engine that sits directly upstream of the memory FIFO in the DSP datapath. On a start command it reads a contiguous block of words from a fixed-latency synchronous memory and pushes each word into the FIFO write port. It tracks FIFO occupancy with a local credit counter, so it never overruns the FIFO and needs no full flag from it.

## Interface
- DATA_WIDTH, 32: data word width in bits.
- ADDR_WIDTH, 16: memory address width; also the width of the length field.
- FIFO_DEPTH, 16: entries in the downstream FIFO; sets the credit limit.
- MEM_LATENCY, 2: cycles from mem_req to valid mem_rdata; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle command strobe
- base_addr  in  ADDR_WIDTH  first word address, sampled on start
- length  in  ADDR_WIDTH  word count, sampled on start
- abort  in  1  stop issuing new reads
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_req
- fifo_wr_en  out  1  FIFO push
- fifo_wr_data  out  DATA_WIDTH  pushed word
- fifo_pop  in  1  downstream FIFO read enable, used for credit return

## Operation
- Reset: state IDLE. busy, done, mem_req, fifo_wr_en, mem_addr, fifo_wr_data, occupancy, in-flight count and return pipeline are all 0. Reads still in flight at reset are discarded.
- IDLE: start with length nonzero latches base_addr and length and moves to FETCH. start with length 0 pulses done on the next cycle and stays in IDLE. start while busy is ignored.
- FETCH: issues mem_req with mem_addr = current address when credit is available. Credit means occupancy + in_flight < FIFO_DEPTH. Each issue increments the address and decrements the remaining count. The address wraps modulo 2^ADDR_WIDTH.
- FETCH moves to DRAIN after the last issue, or on abort. abort in IDLE or DRAIN has no effect.
- DRAIN: no further issues. Outstanding returns are still written to the FIFO. When in_flight reaches 0 the block goes to IDLE and pulses done.
- in_flight increments on mem_req and decrements on fifo_wr_en. If both occur in one cycle it is unchanged.
- occupancy increments on fifo_wr_en. It decrements on fifo_pop only when occupancy > 0; fifo_pop while empty is ignored. Push and pop in the same cycle leave it unchanged.
- occupancy and in_flight are each $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Start accepted at cycle 0: busy = 1 and the first mem_req at cycle 1 when credit exists.
- Sustained throughput is one word per cycle while credit holds.
- mem_rdata is captured at cycle t+MEM_LATENCY for a request at cycle t. fifo_wr_en and fifo_wr_data are registered at cycle t+MEM_LATENCY+1.
- done is asserted the cycle after the final fifo_wr_en. busy deasserts in that same cycle.
- A fifo_pop at cycle n frees credit for a mem_req at cycle n+1.

## Configuration
- MEM_FETCH_CHKSUM_EN defined: adds output chksum [DATA_WIDTH-1:0]. chksum is cleared on an accepted start and XOR-accumulates every fifo_wr_data. It is stable and valid when done pulses, and resets to 0.
- MEM_FETCH_CHKSUM_EN undefined: no chksum port and no accumulator logic.

## Structure
- Shared package mem_fetch_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN);
  - default width constants DATA_WIDTH, ADDR_WIDTH and FIFO_DEPTH.
- One sub-module, mem_fetch_credit: the occupancy and in-flight counters plus the credit comparison.

## Test plan
- Basic block: base_addr=0x0100, length=4, fifo_pop held 1 -> mem_addr 0x0100 to 0x0103 on cycles 1 to 4, four fifo_wr_en pulses at cycles 4 to 7 (MEM_LATENCY=2), done at cycle 8.
- Credit stall: length=20, fifo_pop=0 -> exactly 16 mem_req issued and fifo_wr_en count stops at 16. Popping 3 words releases exactly 3 more reads. done follows the 20th write.
- Wrap: base_addr=0xFFFE, length=4 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Abort: abort asserted after the 5th mem_req with length=10 -> no further mem_req, all 5 words written to the FIFO, then done.
- Zero length and busy start: start with length=0 -> done at cycle 1, no mem_req. A second start while busy is ignored and the original transfer completes unchanged.
- Reset mid-transfer: rst after 3 issues -> all outputs 0 next cycle and no fifo_wr_en from reads still in flight. With MEM_FETCH_CHKSUM_EN and data 1, 2, 4, 8, chksum = 0xF when done pulses.

Source files
------------

// File: rtl/mem_fetch_pkg.sv
// Shared definitions for the memory fetch engine: FSM states and default widths.
// The optional checksum output is enabled by defining MEM_FETCH_CHKSUM_EN.
package mem_fetch_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mem_fetch_if.sv
// Command, memory-read and FIFO-write signals of the fetch engine.
// With MEM_FETCH_CHKSUM_EN defined the interface also carries chksum.
//
// Handshake semantics: start is a one-cycle command strobe taken only while
// busy is low. mem_req is a fire-and-forget read strobe (no ready); its data
// is valid exactly MEM_LATENCY cycles later. fifo_wr_en is a push with no
// back-pressure: the engine's credit counter guarantees the FIFO has room.
// fifo_pop is the downstream read enable and returns one credit when the
// FIFO is not empty.
interface mem_fetch_if #(
  parameter int DW = mem_fetch_pkg::DATA_WIDTH,
  parameter int AW = mem_fetch_pkg::ADDR_WIDTH
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_pop;
`ifdef MEM_FETCH_CHKSUM_EN
  logic [DW-1:0] chksum;

  modport slave (
    input  start, base_addr, length, abort, mem_rdata, fifo_pop,
    output busy, done, mem_req, mem_addr, fifo_wr_en, fifo_wr_data, chksum
  );
  modport master (
    output start, base_addr, length, abort, mem_rdata, fifo_pop,
    input  busy, done, mem_req, mem_addr, fifo_wr_en, fifo_wr_data, chksum
  );
`else
  modport slave (
    input  start, base_addr, length, abort, mem_rdata, fifo_pop,
    output busy, done, mem_req, mem_addr, fifo_wr_en, fifo_wr_data
  );
  modport master (
    output start, base_addr, length, abort, mem_rdata, fifo_pop,
    input  busy, done, mem_req, mem_addr, fifo_wr_en, fifo_wr_data
  );
`endif
endinterface

// File: rtl/mem_fetch_credit.sv
// FIFO occupancy and in-flight read counters. A new read may be issued only
// while occupancy + in_flight is below the FIFO depth, so every outstanding
// read already owns a FIFO slot when its data returns.
module mem_fetch_credit
  import mem_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = mem_fetch_pkg::FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  output logic                          credit_ok_o,
  output logic [$clog2(FIFO_DEPTH):0]   in_flight_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] infl_q, infl_d;
  logic          pop_eff;
  logic [CW:0]   total;

  // Next counter values; a pop on an empty FIFO returns no credit.
  always_comb begin
    pop_eff = pop_i && (occ_q != '0);
    occ_d   = occ_q;
    infl_d  = infl_q;
    if (push_i && !pop_eff)      occ_d = occ_q + CW'(1);
    else if (!push_i && pop_eff) occ_d = occ_q - CW'(1);
    if (issue_i && !push_i)      infl_d = infl_q + CW'(1);
    else if (!issue_i && push_i) infl_d = infl_q - CW'(1);
    total = {1'b0, occ_q} + {1'b0, infl_q};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      infl_q <= '0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
    end
  end

  assign credit_ok_o = (total < (CW+1)'(FIFO_DEPTH));
  assign in_flight_o = infl_q;

endmodule

// File: rtl/mem_fetch_ctrl.sv
// Memory fetch engine: reads a contiguous block from a fixed-latency memory
// and pushes each word into the downstream FIFO, throttled by local credit.
// Defining MEM_FETCH_CHKSUM_EN adds an XOR checksum of all pushed words.
module mem_fetch_ctrl
  import mem_fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = mem_fetch_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = mem_fetch_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH  = mem_fetch_pkg::FIFO_DEPTH,
  parameter int MEM_LATENCY = mem_fetch_pkg::MEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  mem_fetch_if.slave  bus,
  output state_t      state_dbg_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
  logic                    done_q, done_d;
  logic                    issue;
  logic                    credit_ok;
  logic                    drain_empty;
  logic [CW-1:0]           in_flight;
  logic [MEM_LATENCY-1:0]  vld_q, vld_d;
  logic                    wr_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  mem_fetch_credit #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .issue_i     (issue),
    .push_i      (wr_en_q),
    .pop_i       (bus.fifo_pop),
    .credit_ok_o (credit_ok),
    .in_flight_o (in_flight)
  );

  // Nothing is issued in DRAIN, so the block is empty once the read that is
  // being pushed this cycle (if any) was the last one outstanding.
  assign drain_empty = (in_flight == '0) || ((in_flight == CW'(1)) && wr_en_q);

  // Next-state, address/count and issue decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = bus.base_addr;
            remain_d = bus.length;
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        if (bus.abort) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          issue    = 1'b1;
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - ADDR_WIDTH'(1);
          if (remain_q == ADDR_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request-valid pipeline: bit i set means a read issued i+1 cycles ago.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < MEM_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  // State, address, return pipeline and registered FIFO push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      vld_q    <= vld_d;
      wr_en_q  <= vld_q[MEM_LATENCY-1];
      if (vld_q[MEM_LATENCY-1]) wr_data_q <= bus.mem_rdata;
    end
  end

`ifdef MEM_FETCH_CHKSUM_EN
  logic [DATA_WIDTH-1:0] chksum_q;

  // Checksum restarts on an accepted command and folds in every pushed word.
  always_ff @(posedge clk) begin
    if (rst)                             chksum_q <= '0;
    else if (state_q == IDLE && bus.start) chksum_q <= '0;
    else if (wr_en_q)                    chksum_q <= chksum_q ^ wr_data_q;
  end

  assign bus.chksum = chksum_q;
`endif

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.mem_req      = issue;
  assign bus.mem_addr     = addr_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign state_dbg_o      = state_q;

endmodule
